// File: rtl/mult_thread_arbiter.sv
// Round-robin arbiter sharing one single-cycle multiplier between threads, with an
// in-order result buffer. Define MULT_ARB_FLUSH_EN to add per-thread flush.
module mult_thread_arbiter #(
  parameter int NUM_THREADS   = 2,
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 3,
  parameter int RES_DEPTH     = 4,
  parameter int FU_OP_W       = 4,
  localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
  localparam int PW = $clog2(RES_DEPTH)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NUM_THREADS-1:0]                    req_valid_i,
  output logic [NUM_THREADS-1:0]                    req_ready_o,
  input  logic [NUM_THREADS-1:0][FU_OP_W-1:0]       req_op_i,
  input  logic [NUM_THREADS-1:0][XLEN-1:0]          req_a_i,
  input  logic [NUM_THREADS-1:0][XLEN-1:0]          req_b_i,
  input  logic [NUM_THREADS-1:0][TRANS_ID_BITS-1:0] req_trans_id_i,
`ifdef MULT_ARB_FLUSH_EN
  input  logic [NUM_THREADS-1:0]                    flush_i,
`endif
  output logic                                      mul_valid_o,
  output logic [FU_OP_W-1:0]                        mul_op_o,
  output logic [XLEN-1:0]                           mul_a_o,
  output logic [XLEN-1:0]                           mul_b_o,
  output logic [TRANS_ID_BITS-1:0]                  mul_trans_id_o,
  output logic [TW-1:0]                             mul_thread_id_o,
  input  logic                                      mul_valid_i,
  input  logic [XLEN-1:0]                           mul_result_i,
  input  logic [TRANS_ID_BITS-1:0]                  mul_trans_id_i,
  input  logic [TW-1:0]                             mul_thread_id_i,
  output logic                                      wb_valid_o,
  input  logic                                      wb_ready_i,
  output logic [XLEN-1:0]                           wb_result_o,
  output logic [TRANS_ID_BITS-1:0]                  wb_trans_id_o,
  output logic [TW-1:0]                             wb_thread_id_o
);

  logic                     active_q;
  logic [TW-1:0]            rr_q, rr_d;
  logic                     inflight_q;
  logic [PW:0]              count_q, count_d;
  logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [XLEN-1:0]          res_q [RES_DEPTH];
  logic [TRANS_ID_BITS-1:0] tid_q [RES_DEPTH];
  logic [TW-1:0]            thr_q [RES_DEPTH];

  logic [NUM_THREADS-1:0]   eligible_s;
  logic [TW:0]              pick_s;
  logic [TW-1:0]            winner_s;
  logic [PW:0]              credit_s;
  logic                     issue_s, push_s, pop_s, empty_s, full_s;

  // Returns {found, index} of the first requester at or after ptr, wrapping.
  function automatic logic [TW:0] rr_pick(input logic [NUM_THREADS-1:0] req,
                                          input logic [TW-1:0]          ptr);
    int idx;
    rr_pick = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_THREADS;
      if (req[idx]) rr_pick = {1'b1, idx[TW-1:0]};
    end
  endfunction

`ifdef MULT_ARB_FLUSH_EN
  assign eligible_s = req_valid_i & ~flush_i;
`else
  assign eligible_s = req_valid_i;
`endif

  assign pick_s   = rr_pick(eligible_s, rr_q);
  assign winner_s = pick_s[TW-1:0];
  // Free slots once the result currently inside the multiplier has landed.
  assign credit_s = (PW+1)'(RES_DEPTH) - count_q - {{PW{1'b0}}, inflight_q};
  assign issue_s  = active_q & pick_s[TW] & (credit_s != '0);

  always_comb begin
    req_ready_o = '0;
    rr_d        = rr_q;
    if (issue_s) begin
      req_ready_o[winner_s] = 1'b1;
      rr_d = (winner_s == TW'(NUM_THREADS - 1)) ? '0 : winner_s + TW'(1);
    end else begin
      rr_d = rr_q;
    end
  end

  assign mul_valid_o     = issue_s;
  assign mul_op_o        = req_op_i[winner_s];
  assign mul_a_o         = req_a_i[winner_s];
  assign mul_b_o         = req_b_i[winner_s];
  assign mul_trans_id_o  = req_trans_id_i[winner_s];
  assign mul_thread_id_o = winner_s;

  assign empty_s        = (count_q == '0);
  assign full_s         = (count_q == (PW+1)'(RES_DEPTH));
  assign wb_result_o    = res_q[rd_ptr_q];
  assign wb_trans_id_o  = tid_q[rd_ptr_q];
  assign wb_thread_id_o = thr_q[rd_ptr_q];

`ifdef MULT_ARB_FLUSH_EN
  logic [RES_DEPTH-1:0] live_q;

  // A result returning for a thread being flushed this cycle is dropped outright.
  assign push_s     = active_q & mul_valid_i & ~flush_i[mul_thread_id_i];
  assign wb_valid_o = ~empty_s & live_q[rd_ptr_q];
  assign pop_s      = ~empty_s & (~live_q[rd_ptr_q] | wb_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      live_q <= '0;
    end else begin
      for (int i = 0; i < RES_DEPTH; i++) begin
        if (push_s && (wr_ptr_q == PW'(i))) begin
          live_q[i] <= 1'b1;
        end else if (flush_i[thr_q[i]]) begin
          live_q[i] <= 1'b0;
        end else begin
          live_q[i] <= live_q[i];
        end
      end
    end
  end
`else
  assign push_s     = active_q & mul_valid_i;
  assign wb_valid_o = ~empty_s;
  assign pop_s      = wb_valid_o & wb_ready_i;
`endif

  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // active_q holds off grants until the first clock edge after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q   <= 1'b0;
      rr_q       <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < RES_DEPTH; i++) begin
        res_q[i] <= '0;
        tid_q[i] <= '0;
        thr_q[i] <= '0;
      end
    end else begin
      active_q   <= 1'b1;
      rr_q       <= rr_d;
      inflight_q <= issue_s;
      count_q    <= count_d;
      if (push_s) begin
        res_q[wr_ptr_q] <= mul_result_i;
        tid_q[wr_ptr_q] <= mul_trans_id_i;
        thr_q[wr_ptr_q] <= mul_thread_id_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  (push_s && full_s) |-> pop_s);

endmodule

// File: tb/tb_mult_thread_arbiter.sv
// Bench for mult_thread_arbiter: random and directed stimulus checked against a
// queue-based reference model of arbitration, credit and in-order writeback.
module tb_mult_thread_arbiter;
  localparam int N     = 2;
  localparam int XLEN  = 64;
  localparam int TIDW  = 3;
  localparam int DEPTH = 4;
  localparam int OPW   = 4;
  localparam int TW    = 1;

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic [TIDW-1:0] tid;
    logic [TW-1:0]   thr;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]           req_valid = '0, req_ready, flush = '0;
  logic [N-1:0][OPW-1:0]  req_op = '0;
  logic [N-1:0][XLEN-1:0] req_a = '0, req_b = '0;
  logic [N-1:0][TIDW-1:0] req_tid = '0;
  logic            mul_valid, mv_q, wb_valid, wb_ready = 1'b0;
  logic [OPW-1:0]  mul_op;
  logic [XLEN-1:0] mul_a, mul_b, mres_q, wb_res;
  logic [TIDW-1:0] mul_tid, mtid_q, wb_tid;
  logic [TW-1:0]   mul_thr, mthr_q, wb_thr;

  int   checks = 0, errors = 0;
  int   m_rr = 0, p_win = 0;
  bit   m_active = 0, m_infl = 0, p_issue = 0;
  res_t m_infl_ent;
  res_t m_q[$];
  logic [N-1:0] exp_rdy;

  always #5 clk = ~clk;

  mult_thread_arbiter #(.NUM_THREADS(N), .XLEN(XLEN), .TRANS_ID_BITS(TIDW),
                        .RES_DEPTH(DEPTH), .FU_OP_W(OPW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_a_i(req_a), .req_b_i(req_b), .req_trans_id_i(req_tid),
`ifdef MULT_ARB_FLUSH_EN
    .flush_i(flush),
`endif
    .mul_valid_o(mul_valid), .mul_op_o(mul_op), .mul_a_o(mul_a), .mul_b_o(mul_b),
    .mul_trans_id_o(mul_tid), .mul_thread_id_o(mul_thr),
    .mul_valid_i(mv_q), .mul_result_i(mres_q), .mul_trans_id_i(mtid_q),
    .mul_thread_id_i(mthr_q),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_result_o(wb_res),
    .wb_trans_id_o(wb_tid), .wb_thread_id_o(wb_thr)
  );

  // Multiplier: result one cycle after issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv_q <= 1'b0; mres_q <= '0; mtid_q <= '0; mthr_q <= '0;
    end else begin
      mv_q <= mul_valid; mres_q <= mul_a * mul_b; mtid_q <= mul_tid; mthr_q <= mul_thr;
    end
  end

  task automatic predict();
    bit found;
    int t;
    found = 0; p_win = 0;
    for (int k = 0; k < N; k++) begin
      t = (m_rr + k) % N;
      if (!found && req_valid[t] && !flush[t]) begin found = 1; p_win = t; end
    end
    p_issue = m_active && found && ((DEPTH - m_q.size() - int'(m_infl)) > 0);
    exp_rdy = p_issue ? (N'(1) << p_win) : '0;
  endtask

  task automatic sample();
    @(negedge clk);
    predict();
  endtask

  task automatic advance();
    res_t keep[$];
    bit   clr;
    int   clr_t;
    predict();
    clr = 0; clr_t = 0;
    @(posedge clk);
    if (!rst_n) begin
      m_rr = 0; m_active = 0; m_infl = 0; m_q.delete();
    end else if (!m_active) begin
      m_active = 1;
    end else begin
      if (m_q.size() > 0 && wb_ready) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_infl_ent);
      if (flush != '0) begin
        foreach (m_q[j]) if (!flush[m_q[j].thr]) keep.push_back(m_q[j]);
        m_q = keep;
      end
      m_infl = p_issue;
      if (p_issue) begin
        m_infl_ent.res = req_a[p_win] * req_b[p_win];
        m_infl_ent.tid = req_tid[p_win];
        m_infl_ent.thr = TW'(p_win);
        m_rr = (p_win + 1) % N;
        clr = 1; clr_t = p_win;
      end
    end
    #1;
    if (clr) req_valid[clr_t] = 1'b0;
  endtask

  task automatic refill(input logic [N-1:0] mask);
    for (int t = 0; t < N; t++) begin
      if (mask[t] && !req_valid[t]) begin
        req_valid[t] = 1'b1;
        req_a[t]     = {$urandom, $urandom};
        req_b[t]     = {$urandom, $urandom};
        req_tid[t]   = TIDW'($urandom);
        req_op[t]    = OPW'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; wb_ready = 1'b0; flush = '0;
    advance(); advance();
    rst_n = 1'b1;
    advance();
  endtask

  task automatic test_reset();
    refill(2'b11); wb_ready = 1'b1;
    sample();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready got %b exp 00", req_ready); end
    checks++; if (mul_valid !== 1'b0) begin errors++; $display("FAIL rst_mul_valid got %b exp 0", mul_valid); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got %b exp 0", wb_valid); end
    advance();
    rst_n = 1'b1;
    sample();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rel_ready got %b exp 00", req_ready); end
    advance();
    sample();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL first_grant got %b exp 01", req_ready); end
    advance();
  endtask

  task automatic test_alternate();
    do_reset();
    wb_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      refill(2'b11);
      sample();
      checks++;
      if (mul_valid !== 1'b1 || mul_thr !== TW'(i % 2)) begin
        errors++; $display("FAIL alt_grant cyc %0d got v=%b t=%0d exp v=1 t=%0d", i, mul_valid, mul_thr, i % 2);
      end
      checks++;
      if (wb_valid !== (i >= 2)) begin
        errors++; $display("FAIL alt_wb_valid cyc %0d got %b exp %b", i, wb_valid, i >= 2);
      end
      if (i >= 2 && m_q.size() > 0) begin
        checks++;
        if ({wb_res, wb_tid, wb_thr} !== m_q[0]) begin
          errors++; $display("FAIL alt_wb_data cyc %0d got %h exp %h", i, {wb_res, wb_tid, wb_thr}, m_q[0]);
        end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    int n_iss;
    do_reset();
    wb_ready = 1'b0; n_iss = 0;
    for (int i = 0; i < 8; i++) begin
      refill(2'b01);
      sample();
      if (mul_valid) n_iss++;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL bp_ready cyc %0d got %b exp %b", i, req_ready, exp_rdy); end
      advance();
    end
    checks++; if (n_iss !== DEPTH) begin errors++; $display("FAIL bp_issue_count got %0d exp %0d", n_iss, DEPTH); end
    refill(2'b01);
    sample();
    checks++; if (req_ready !== 2'b00 || wb_valid !== 1'b1) begin errors++; $display("FAIL bp_stalled got rdy=%b wbv=%b exp rdy=00 wbv=1", req_ready, wb_valid); end
    advance();
    wb_ready = 1'b1;
    sample();
    checks++; if (mul_valid !== 1'b0) begin errors++; $display("FAIL bp_pop_cycle_issue got %b exp 0", mul_valid); end
    advance();
    sample();
    checks++; if (mul_valid !== 1'b1) begin errors++; $display("FAIL bp_resume got %b exp 1", mul_valid); end
    advance();
  endtask

  task automatic test_full_drain();
    for (int i = 0; i < 10; i++) begin
      refill(2'b01);
      sample();
      checks++;
      if (wb_valid !== 1'b1 || mul_valid !== 1'b1) begin
        errors++; $display("FAIL drain_flow cyc %0d got wbv=%b mv=%b exp 1 1", i, wb_valid, mul_valid);
      end
      if (m_q.size() > 0) begin
        checks++;
        if ({wb_res, wb_tid, wb_thr} !== m_q[0]) begin
          errors++; $display("FAIL drain_data cyc %0d got %h exp %h", i, {wb_res, wb_tid, wb_thr}, m_q[0]);
        end
      end
      advance();
    end
  endtask

  task automatic test_single_mul();
    do_reset();
    wb_ready = 1'b0;
    req_a[1] = 64'd3; req_b[1] = 64'd5; req_tid[1] = 3'd2; req_op[1] = 4'h1; req_valid = 2'b10;
    sample();
    checks++;
    if (mul_valid !== 1'b1 || mul_thr !== 1'b1 || mul_a !== 64'd3 || mul_b !== 64'd5 || mul_tid !== 3'd2 || req_ready !== 2'b10) begin
      errors++; $display("FAIL mul_issue got v=%b t=%0d a=%0d b=%0d id=%0d rdy=%b exp 1 1 3 5 2 10", mul_valid, mul_thr, mul_a, mul_b, mul_tid, req_ready);
    end
    advance();
    sample();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL mul_lat1 got %b exp 0", wb_valid); end
    advance();
    for (int i = 0; i < 2; i++) begin
      sample();
      checks++;
      if (wb_valid !== 1'b1 || wb_res !== 64'd15 || wb_tid !== 3'd2 || wb_thr !== 1'b1) begin
        errors++; $display("FAIL mul_wb cyc %0d got v=%b r=%0d id=%0d t=%0d exp 1 15 2 1", i, wb_valid, wb_res, wb_tid, wb_thr);
      end
      advance();
    end
    wb_ready = 1'b1;
    sample();
    checks++; if (wb_valid !== 1'b1 || wb_res !== 64'd15) begin errors++; $display("FAIL mul_pop got v=%b r=%0d exp 1 15", wb_valid, wb_res); end
    advance();
    sample();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL mul_empty got %b exp 0", wb_valid); end
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      refill(N'($urandom));
      wb_ready = ($urandom_range(0, 3) != 0);
      sample();
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", i, req_ready, exp_rdy); end
      checks++; if (mul_valid !== p_issue) begin errors++; $display("FAIL rnd_mul_valid cyc %0d got %b exp %b", i, mul_valid, p_issue); end
      if (p_issue) begin
        checks++;
        if (mul_thr !== TW'(p_win) || mul_a !== req_a[p_win] || mul_b !== req_b[p_win] ||
            mul_tid !== req_tid[p_win] || mul_op !== req_op[p_win]) begin
          errors++; $display("FAIL rnd_mul_fields cyc %0d got t=%0d a=%h exp t=%0d a=%h", i, mul_thr, mul_a, p_win, req_a[p_win]);
        end
      end
      checks++; if (wb_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_wb_valid cyc %0d got %b exp %b", i, wb_valid, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        checks++;
        if ({wb_res, wb_tid, wb_thr} !== m_q[0]) begin
          errors++; $display("FAIL rnd_wb_data cyc %0d got %h exp %h", i, {wb_res, wb_tid, wb_thr}, m_q[0]);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      refill(2'b11);
      sample();
      advance();
    end
    req_valid = '0;
    sample(); advance(); sample(); advance();
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL mid_buffered got %b exp 1", wb_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_wb got %b exp 0", wb_valid); end
    advance();
    rst_n = 1'b1;
    refill(2'b11);
    sample();
    advance();
    sample();
    checks++; if (req_ready !== 2'b01 || mul_thr !== 1'b0) begin errors++; $display("FAIL mid_rr_reset got rdy=%b t=%0d exp 01 0", req_ready, mul_thr); end
    advance();
  endtask

`ifdef MULT_ARB_FLUSH_EN
  task automatic test_flush();
    logic [XLEN-1:0] prod1;
    int n_wb, n_iss;
    do_reset();
    wb_ready = 1'b0; prod1 = '0;
    for (int i = 0; i < 3; i++) begin
      refill((i == 2) ? 2'b01 : 2'b11);
      sample();
      if (i == 1) prod1 = req_a[1] * req_b[1];
      advance();
    end
    req_valid = '0;
    sample(); advance(); sample(); advance();
    flush = 2'b01;
    sample(); advance();
    flush = 2'b00; wb_ready = 1'b1; n_wb = 0;
    for (int i = 0; i < 8; i++) begin
      sample();
      if (wb_valid) begin
        n_wb++;
        checks++;
        if (wb_thr !== 1'b1 || wb_res !== prod1) begin
          errors++; $display("FAIL flush_wb got t=%0d r=%h exp 1 %h", wb_thr, wb_res, prod1);
        end
      end
      advance();
    end
    checks++; if (n_wb !== 1) begin errors++; $display("FAIL flush_wb_count got %0d exp 1", n_wb); end
    wb_ready = 1'b0; n_iss = 0;
    for (int i = 0; i < 8; i++) begin
      refill(2'b01);
      sample();
      if (mul_valid) n_iss++;
      advance();
    end
    checks++; if (n_iss !== DEPTH) begin errors++; $display("FAIL flush_credit got %0d exp %0d", n_iss, DEPTH); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    test_reset();
    test_alternate();
    test_backpressure();
    test_full_drain();
    test_single_mul();
    test_random();
    test_reset_mid();
`ifdef MULT_ARB_FLUSH_EN
    test_flush();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
